// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) tile scheduler.
package winograd_pkg;

    // Fixed depth of the processing_element pipeline, data_in/next to data_out/next_out.
    localparam int unsigned PE_LATENCY = 74;

    // Width of the coordinate fields carried in a tile tag.
    localparam int unsigned TAG_COORD_W = 8;

    // Identity of one tile as it travels alongside the PE pipeline.
    typedef struct packed {
        logic [TAG_COORD_W-1:0] x;
        logic [TAG_COORD_W-1:0] y;
        logic                   last;
    } tile_tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sched_state_t;

endpackage

// File: rtl/tile_tag_delay.sv
// Fixed-length delay line carrying {valid, tile_tag_t} in lockstep with the PE pipeline.
// Only the valid bits are reset; stale payload behind a cleared valid is harmless.
module tile_tag_delay
    import winograd_pkg::*;
#(
    parameter int unsigned Depth = PE_LATENCY
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    input  tile_tag_t in_tag,
    output logic      out_valid,
    output tile_tag_t out_tag
);

    logic [Depth-1:0] valid_q, valid_d;
    tile_tag_t        tag_q [Depth];
    tile_tag_t        tag_d [Depth];

    // Shift every stage by one position, inserting the new tag at stage 0.
    always_comb begin
        valid_d = {valid_q[Depth-2:0], in_valid};
        tag_d[0] = in_tag;
        for (int i = 1; i < Depth; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Valid bits: asynchronously cleared so a reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload bits: no reset needed, qualified by the valid bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            tag_q[i] <= tag_d[i];
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_tag   = tag_q[Depth-1];

endmodule

// File: rtl/winograd_tile_scheduler.sv
// Raster-order tile issuer for the Winograd PE: credit-gated issue, coordinate tagging
// through a delay line matched to the PE latency, and an end-of-plane done pulse.
module winograd_tile_scheduler
    import winograd_pkg::*;
#(
    parameter int unsigned PE_LATENCY = winograd_pkg::PE_LATENCY,
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned COORD_W    = winograd_pkg::TAG_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] num_tiles_x,
    input  logic [COORD_W-1:0] num_tiles_y,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               pe_next,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_tile_x,
    output logic [COORD_W-1:0] out_tile_y,
    output logic               out_last,
    input  logic               credit_return,
    output logic               err_credit
);

    localparam int unsigned CredW   = $clog2(BUF_DEPTH + 1);
    localparam int unsigned FlightW = $clog2(PE_LATENCY + 1);

    sched_state_t       state_q, state_d;
    logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [CredW-1:0]   credits_q, credits_d;
    logic [FlightW-1:0] in_flight_q, in_flight_d;
    logic               err_credit_q, err_credit_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic      issue, x_last, y_last, credit_overflow, credit_inc;
    logic      tag_valid;
    tile_tag_t issue_tag, tag_out;

    assign in_ready = (state_q == StRun) && (credits_q != '0);
    assign issue    = in_valid & in_ready;
    assign pe_next  = issue;

    assign x_last = (x_q == nx_q - COORD_W'(1));
    assign y_last = (y_q == ny_q - COORD_W'(1));

    assign issue_tag.x    = x_q;
    assign issue_tag.y    = y_q;
    assign issue_tag.last = x_last & y_last;

    // Plane sequencing: grid latch, raster walk and end-of-plane detection.
    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    nx_d = num_tiles_x;
                    ny_d = num_tiles_y;
                    x_d  = '0;
                    y_d  = '0;
                    // An empty grid has nothing to issue; finish straight away.
                    state_d = ((num_tiles_x == '0) || (num_tiles_y == '0)) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                    if (issue_tag.last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (in_flight_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Credit and in-flight bookkeeping; a return with every entry already free is an error.
    always_comb begin
        credit_overflow = credit_return && (credits_q == CredW'(BUF_DEPTH));
        credit_inc      = credit_return & ~credit_overflow;
        err_credit_d    = err_credit_q | credit_overflow;

        credits_d = credits_q;
        if (issue && !credit_inc) begin
            credits_d = credits_q - CredW'(1);
        end else if (credit_inc && !issue) begin
            credits_d = credits_q + CredW'(1);
        end

        in_flight_d = in_flight_q;
        if (issue && !tag_valid) begin
            in_flight_d = in_flight_q + FlightW'(1);
        end else if (tag_valid && !issue) begin
            in_flight_d = in_flight_q - FlightW'(1);
        end
    end

    // All scheduler state, including the registered busy/done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            nx_q         <= '0;
            ny_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            credits_q    <= CredW'(BUF_DEPTH);
            in_flight_q  <= '0;
            err_credit_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            x_q          <= x_d;
            y_q          <= y_d;
            credits_q    <= credits_d;
            in_flight_q  <= in_flight_d;
            err_credit_q <= err_credit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    tile_tag_delay #(
        .Depth (PE_LATENCY)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (issue),
        .in_tag    (issue_tag),
        .out_valid (tag_valid),
        .out_tag   (tag_out)
    );

    // Payload is unreset, so coordinates are masked to zero whenever no result is present.
    assign out_valid  = tag_valid;
    assign out_tile_x = tag_valid ? tag_out.x : '0;
    assign out_tile_y = tag_valid ? tag_out.y : '0;
    assign out_last   = tag_valid & tag_out.last;

    assign busy       = busy_q;
    assign done       = done_q;
    assign err_credit = err_credit_q;

endmodule
